rc4_s_init: RTL and testbench

S-array initialisation engine for the RC4 decryption datapath. On request it fills the 256×8 state memory `s_memory` with the identity permutation S[i] = i for i = 0..255. It then signals completion so the key-scheduling stage can take over. It drives the memory's address, data and write-enable pins directly and owns the memory port while running.

---
 rtl/rc4_s_init.sv | 79 +++++++
 tb/tb_rc4_s_init.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rc4_s_init.sv
// RC4 S-array initialisation engine: writes S[i] = i for i = 0..255 into s_memory,
// then holds task1_done until start_task1 is released.
module rc4_s_init (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_task1,
  output logic       s_wren,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       task1_done
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wren_q;
  logic              done_q;

  // State, counter and Moore output flops; outputs decoded from next state so they are pure registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wren_q  <= (state_d == WRITE);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_task1) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // start_task1 is deliberately ignored here: a run always finishes.
        if (cnt_q == CntLast) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        cnt_d = '0;
        if (!start_task1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign s_wren     = wren_q;
  assign s_address  = cnt_q;
  assign s_data     = cnt_q;
  assign task1_done = done_q;

endmodule

// File: tb/tb_rc4_s_init.sv
// Bench for rc4_s_init: directed sequence with randomized timing, checked against
// an expected write schedule and a behavioural model of the attached s_memory.
module tb_rc4_s_init;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_task1;
  logic       s_wren;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       task1_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];
  int         wlog [$];

  rc4_s_init dut (
    .clk         (clk),
    .reset       (reset),
    .start_task1 (start_task1),
    .s_wren      (s_wren),
    .s_address   (s_address),
    .s_data      (s_data),
    .task1_done  (task1_done)
  );

  always #5 clk = ~clk;

  // Model of s_memory: synchronous write of the values presented before the edge.
  always @(posedge clk) begin
    if (s_wren === 1'b1) begin
      mem[s_address] = s_data;
      wlog.push_back(int'(s_address));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic exp_done);
    chk({tag, "_wren"}, 32'(s_wren), 32'd0);
    chk({tag, "_addr"}, 32'(s_address), 32'd0);
    chk({tag, "_data"}, 32'(s_data), 32'd0);
    chk({tag, "_done"}, 32'(task1_done), 32'(exp_done));
  endtask

  // Follows one run whose E0 is the next rising edge; writes k appear after E0+k.
  // drop_at >= 0 deasserts start_task1 right after address drop_at is observed.
  task automatic follow_run(input string tag, input int drop_at);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      chk({tag, "_wren"}, 32'(s_wren), 32'd1);
      chk({tag, "_addr"}, 32'(s_address), 32'(k));
      chk({tag, "_data"}, 32'(s_data), 32'(k));
      chk({tag, "_done_low"}, 32'(task1_done), 32'd0);
      if (k == drop_at) start_task1 = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_end_wren"}, 32'(s_wren), 32'd0);
    chk({tag, "_end_done"}, 32'(task1_done), 32'd1);
  endtask

  // The write log must be exactly 0,1,...,255 once each, in order.
  task automatic chk_log(input string tag);
    chk({tag, "_log_len"}, 32'(wlog.size()), 32'd256);
    if (wlog.size() == 256) begin
      for (int i = 0; i < 256; i++) chk({tag, "_log_entry"}, 32'(wlog[i]), 32'(i));
    end
  endtask

  initial begin
    int mid_len;
    int hold;
    int gap;

    for (int i = 0; i < 256; i++) mem[i] = 8'hA5 ^ 8'(i * 7);

    // Reset values with start requested.
    reset       = 1'b1;
    start_task1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_quiet("reset_hold", 1'b0);
    end

    // Full run after reset release, then memory readback.
    wlog.delete();
    reset = 1'b0;
    follow_run("run1", -1);
    chk_log("run1");
    for (int a = 0; a < 256; a++) chk("mem_readback", 32'(mem[a]), 32'(a));

    // Handshake: stay in DONE for a random time, then drop and re-raise.
    hold = int'($urandom_range(5, 20));
    wlog.delete();
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("done_hold_done", 32'(task1_done), 32'd1);
      chk("done_hold_wren", 32'(s_wren), 32'd0);
    end
    chk("done_hold_nowrites", 32'(wlog.size()), 32'd0);
    start_task1 = 1'b0;
    @(negedge clk);
    chk_quiet("done_release", 1'b0);
    gap = int'($urandom_range(0, 5));
    for (int c = 0; c < gap; c++) begin
      @(negedge clk);
      chk_quiet("idle_gap", 1'b0);
    end
    wlog.delete();
    start_task1 = 1'b1;
    follow_run("run2", -1);
    chk_log("run2");

    // Reset mid-run: partial write then abort.
    start_task1 = 1'b0;
    @(negedge clk);
    chk_quiet("pre_mid", 1'b0);
    start_task1 = 1'b1;
    mid_len = int'($urandom_range(40, 80));
    for (int k = 0; k < mid_len; k++) begin
      @(negedge clk);
      chk("mid_addr", 32'(s_address), 32'(k));
      chk("mid_wren", 32'(s_wren), 32'd1);
    end
    reset = 1'b1;
    #1;
    chk_quiet("mid_reset_async", 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_quiet("mid_reset_hold", 1'b0);
    end
    wlog.delete();
    reset = 1'b0;
    follow_run("run3", -1);
    chk_log("run3");

    // Start dropped mid-write: run completes, done pulses one cycle.
    start_task1 = 1'b0;
    @(negedge clk);
    chk_quiet("pre_drop", 1'b0);
    wlog.delete();
    start_task1 = 1'b1;
    follow_run("run4", 8'h80);
    chk_log("run4");
    @(negedge clk);
    chk_quiet("drop_pulse_end", 1'b0);

    // Idle: after reset with no request, nothing happens for 300 cycles.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wlog.delete();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      chk("idle_wren", 32'(s_wren), 32'd0);
      chk("idle_done", 32'(task1_done), 32'd0);
    end
    chk("idle_nowrites", 32'(wlog.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
